// File: rtl/urv_mem_responder_pkg.sv
// Shared definitions for the uRV memory responder: FSM encoding, wait-counter
// width and the byte-lane merge used by the RAM write/bypass path.
package urv_mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } mem_state_t;

  localparam int WAIT_CNT_W = 4;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = sel[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/urv_mem_responder_dpram.sv
// Dual-port word RAM: port A registered read (fetch), port B registered read
// plus byte-enabled write (data). Cross-port read-during-write returns old data.
module urv_mem_responder_dpram
  import urv_mem_responder_pkg::*;
#(
  parameter int g_mem_words_log2 = 12
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic [g_mem_words_log2-1:0] a_addr,
  output logic [31:0]                 a_q,
  input  logic                        b_rd_en,
  input  logic [g_mem_words_log2-1:0] b_raddr,
  input  logic                        b_we,
  input  logic [g_mem_words_log2-1:0] b_waddr,
  input  logic [3:0]                  b_sel,
  input  logic [31:0]                 b_wdata,
  output logic [31:0]                 b_q
);

  localparam int WORDS = 1 << g_mem_words_log2;

  logic [31:0] mem [0:WORDS-1];
  logic        b_same_word;
  logic [31:0] b_rd_word;

  assign b_same_word = b_we && (b_waddr == b_raddr);
  assign b_rd_word   = b_same_word ? merge_lanes(mem[b_raddr], b_wdata, b_sel)
                                   : mem[b_raddr];

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (b_we && b_sel[i]) begin
        mem[b_waddr][8*i +: 8] <= b_wdata[8*i +: 8];
      end
    end
  end

  // Output registers; port B forwards a same-edge write so a load issued on
  // the completing edge of a store sees the stored lanes.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= mem[a_addr];
      if (b_rd_en) begin
        b_q <= b_rd_word;
      end
    end
  end

endmodule

// File: rtl/urv_mem_responder.sv
// Memory-side responder for the uRV fetch and data ports, with programmable
// load/store wait states in front of the data-port completion pulses.
module urv_mem_responder
  import urv_mem_responder_pkg::*;
#(
  parameter int g_mem_words_log2 = 12,
  parameter int g_load_wait      = 1,
  parameter int g_store_wait     = 0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] im_addr_i,
  output logic [31:0] im_data_o,
  output logic        im_valid_o,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_store_i,
  input  logic        dm_load_i,
  output logic [31:0] dm_data_l_o,
  output logic        dm_ready_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o
);

  localparam int AW = g_mem_words_log2;
  localparam logic [WAIT_CNT_W-1:0] LOAD_W  = WAIT_CNT_W'(g_load_wait);
  localparam logic [WAIT_CNT_W-1:0] STORE_W = WAIT_CNT_W'(g_store_wait);

  mem_state_t             state;
  logic [WAIT_CNT_W-1:0]  cnt;
  logic                   lat_store;
  logic [AW-1:0]          lat_idx;
  logic [31:0]            lat_data;
  logic [3:0]             lat_sel;

  logic                   accept;
  logic [WAIT_CNT_W-1:0]  wait_init;
  logic [AW-1:0]          im_idx;
  logic [AW-1:0]          dm_idx;
  logic                   ram_rd_en;
  logic [AW-1:0]          ram_raddr;
  logic                   ram_we;
  logic                   unused_addr_bits;

  assign im_idx    = im_addr_i[AW+1:2];
  assign dm_idx    = dm_addr_i[AW+1:2];
  assign unused_addr_bits = ^{im_addr_i[31:AW+2], im_addr_i[1:0],
                              dm_addr_i[31:AW+2], dm_addr_i[1:0]};

  // Store wins over a simultaneous load; the load is simply not latched.
  assign accept    = (dm_load_i | dm_store_i) & dm_ready_o;
  assign wait_init = dm_store_i ? STORE_W : LOAD_W;

  assign ram_we    = (state == ST_DONE) & lat_store;

  // The RAM read for a load is launched on the edge that enters DONE.
  assign ram_rd_en = (accept & ~dm_store_i & (LOAD_W == '0)) |
                     ((state == ST_WAIT) & (cnt == WAIT_CNT_W'(1)) & ~lat_store);
  assign ram_raddr = accept ? dm_idx : lat_idx;

  urv_mem_responder_dpram #(
    .g_mem_words_log2(AW)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .a_addr  (im_idx),
    .a_q     (im_data_o),
    .b_rd_en (ram_rd_en),
    .b_raddr (ram_raddr),
    .b_we    (ram_we),
    .b_waddr (lat_idx),
    .b_sel   (lat_sel),
    .b_wdata (lat_data),
    .b_q     (dm_data_l_o)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      im_valid_o <= 1'b0;
    end else begin
      im_valid_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      lat_idx  <= dm_idx;
      lat_data <= dm_data_s_i;
      lat_sel  <= dm_data_select_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      lat_store       <= 1'b0;
      dm_ready_o      <= 1'b1;
      dm_load_done_o  <= 1'b0;
      dm_store_done_o <= 1'b0;
    end else begin
      dm_load_done_o  <= 1'b0;
      dm_store_done_o <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            lat_store <= dm_store_i;
            if (wait_init == '0) begin
              state           <= ST_DONE;
              cnt             <= '0;
              dm_ready_o      <= 1'b1;
              dm_store_done_o <= dm_store_i;
              dm_load_done_o  <= ~dm_store_i;
            end else begin
              state      <= ST_WAIT;
              cnt        <= wait_init;
              dm_ready_o <= 1'b0;
            end
          end else begin
            state      <= ST_IDLE;
            dm_ready_o <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (cnt == WAIT_CNT_W'(1)) begin
            state           <= ST_DONE;
            cnt             <= '0;
            dm_ready_o      <= 1'b1;
            dm_store_done_o <= lat_store;
            dm_load_done_o  <= ~lat_store;
          end else begin
            cnt        <= cnt - WAIT_CNT_W'(1);
            dm_ready_o <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          cnt        <= '0;
          dm_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_urv_mem_responder.sv
// Directed bench: dut_a runs with no wait states, dut_b with load wait 3 and
// store wait 2; they share address/data buses but have private strobes.
module tb_urv_mem_responder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] im_addr, dm_addr, dm_wdata;
  logic [3:0]  dm_sel;
  logic        st_a, ld_a, st_b, ld_b;

  logic [31:0] im_data_a, dl_a, im_data_b, dl_b;
  logic        im_valid_a, rdy_a, ldn_a, sdn_a;
  logic        im_valid_b, rdy_b, ldn_b, sdn_b;

  urv_mem_responder #(.g_mem_words_log2(12), .g_load_wait(0), .g_store_wait(0)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n),
    .im_addr_i(im_addr), .im_data_o(im_data_a), .im_valid_o(im_valid_a),
    .dm_addr_i(dm_addr), .dm_data_s_i(dm_wdata), .dm_data_select_i(dm_sel),
    .dm_store_i(st_a), .dm_load_i(ld_a), .dm_data_l_o(dl_a),
    .dm_ready_o(rdy_a), .dm_load_done_o(ldn_a), .dm_store_done_o(sdn_a)
  );

  urv_mem_responder #(.g_mem_words_log2(12), .g_load_wait(3), .g_store_wait(2)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n),
    .im_addr_i(im_addr), .im_data_o(im_data_b), .im_valid_o(im_valid_b),
    .dm_addr_i(dm_addr), .dm_data_s_i(dm_wdata), .dm_data_select_i(dm_sel),
    .dm_store_i(st_b), .dm_load_i(ld_b), .dm_data_l_o(dl_b),
    .dm_ready_o(rdy_b), .dm_load_done_o(ldn_b), .dm_store_done_o(sdn_b)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic a_op(input logic is_st, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] sel, output logic sdn, output logic ldn,
                      output logic [31:0] dl);
    dm_addr = addr; dm_wdata = data; dm_sel = sel;
    st_a = is_st; ld_a = ~is_st;
    step;
    sdn = sdn_a; ldn = ldn_a; dl = dl_a;
    st_a = 1'b0; ld_a = 1'b0;
  endtask

  task automatic b_op(input logic is_st, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] sel, output logic ok, output logic [31:0] dl);
    dm_addr = addr; dm_wdata = data; dm_sel = sel;
    st_b = is_st; ld_b = ~is_st;
    ok = 1'b0; dl = '0;
    step;
    st_b = 1'b0; ld_b = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (is_st ? sdn_b : ldn_b) begin
        ok = 1'b1;
        dl = dl_b;
        break;
      end
      step;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    im_addr = '0; dm_addr = '0; dm_wdata = '0; dm_sel = '0;
    st_a = 0; ld_a = 0; st_b = 0; ld_b = 0;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (im_valid_b !== 1'b0) begin errors++; $display("FAIL rst_im_valid: got %b want 0", im_valid_b); end
    checks++; if (im_data_b !== 32'h0) begin errors++; $display("FAIL rst_im_data: got %h want 0", im_data_b); end
    checks++; if (dl_b !== 32'h0) begin errors++; $display("FAIL rst_data_l: got %h want 0", dl_b); end
    checks++; if (rdy_b !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", rdy_b); end
    checks++; if (ldn_b !== 1'b0 || sdn_b !== 1'b0) begin errors++; $display("FAIL rst_done: got %b%b want 00", ldn_b, sdn_b); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (im_valid_a !== 1'b0) begin errors++; $display("FAIL rst_valid_before_edge: got %b want 0", im_valid_a); end
    step;
    checks++; if (im_valid_a !== 1'b1) begin errors++; $display("FAIL rst_valid_after_edge: got %b want 1", im_valid_a); end
  endtask

  task automatic test_w0;
    dm_addr = 32'h100; dm_wdata = 32'hDEADBEEF; dm_sel = 4'hF; st_a = 1'b1;
    checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL w0_ready_c0: got %b want 1", rdy_a); end
    step;
    checks++; if (sdn_a !== 1'b1) begin errors++; $display("FAIL w0_store_done: got %b want 1", sdn_a); end
    checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL w0_ready_c1: got %b want 1", rdy_a); end
    st_a = 1'b0; ld_a = 1'b1;
    step;
    checks++; if (ldn_a !== 1'b1) begin errors++; $display("FAIL w0_load_done: got %b want 1", ldn_a); end
    checks++; if (dl_a !== 32'hDEADBEEF) begin errors++; $display("FAIL w0_load_data: got %h want deadbeef", dl_a); end
    checks++; if (sdn_a !== 1'b0) begin errors++; $display("FAIL w0_store_done_once: got %b want 0", sdn_a); end
    checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL w0_ready_c2: got %b want 1", rdy_a); end
    ld_a = 1'b0;
    step;
    checks++; if (ldn_a !== 1'b0) begin errors++; $display("FAIL w0_load_pulse: got %b want 0", ldn_a); end
    checks++; if (dl_a !== 32'hDEADBEEF) begin errors++; $display("FAIL w0_data_hold: got %h want deadbeef", dl_a); end
  endtask

  task automatic test_byte_lanes;
    logic sdn, ldn;
    logic [31:0] dl;
    a_op(1'b1, 32'h200, 32'hAABBCCDD, 4'hF, sdn, ldn, dl);
    a_op(1'b1, 32'h200, 32'h11223344, 4'b0101, sdn, ldn, dl);
    checks++; if (sdn !== 1'b1) begin errors++; $display("FAIL lanes_store_done: got %b want 1", sdn); end
    a_op(1'b0, 32'h200, 32'h0, 4'h0, sdn, ldn, dl);
    checks++; if (ldn !== 1'b1 || dl !== 32'hAA22CC44) begin errors++; $display("FAIL lanes_merge: got %b/%h want 1/aa22cc44", ldn, dl); end
    a_op(1'b1, 32'h200, 32'hFFFFFFFF, 4'h0, sdn, ldn, dl);
    checks++; if (sdn !== 1'b1) begin errors++; $display("FAIL lanes_sel0_done: got %b want 1", sdn); end
    a_op(1'b0, 32'h200, 32'h0, 4'h0, sdn, ldn, dl);
    checks++; if (dl !== 32'hAA22CC44) begin errors++; $display("FAIL lanes_sel0_nowrite: got %h want aa22cc44", dl); end
  endtask

  task automatic test_alias;
    logic sdn, ldn;
    logic [31:0] dl;
    a_op(1'b1, 32'h8, 32'h11111111, 4'hF, sdn, ldn, dl);
    im_addr = 32'h8;
    a_op(1'b1, 32'h0000_4008, 32'hCAFEF00D, 4'hF, sdn, ldn, dl);
    checks++; if (sdn !== 1'b1) begin errors++; $display("FAIL alias_store_done: got %b want 1", sdn); end
    step;
    checks++; if (im_data_a !== 32'h11111111) begin errors++; $display("FAIL alias_fetch_old: got %h want 11111111", im_data_a); end
    step;
    checks++; if (im_data_a !== 32'hCAFEF00D) begin errors++; $display("FAIL alias_fetch_new: got %h want cafef00d", im_data_a); end
    a_op(1'b0, 32'h8, 32'h0, 4'h0, sdn, ldn, dl);
    checks++; if (ldn !== 1'b1 || dl !== 32'hCAFEF00D) begin errors++; $display("FAIL alias_load: got %b/%h want 1/cafef00d", ldn, dl); end
  endtask

  task automatic test_simultaneous;
    logic sdn, ldn;
    logic [31:0] dl;
    dm_addr = 32'h20; dm_wdata = 32'h5; dm_sel = 4'hF; st_a = 1'b1; ld_a = 1'b1;
    step;
    checks++; if (sdn_a !== 1'b1 || ldn_a !== 1'b0) begin errors++; $display("FAIL simul_done: got s%b l%b want s1 l0", sdn_a, ldn_a); end
    checks++; if (dl_a !== 32'hCAFEF00D) begin errors++; $display("FAIL simul_data_hold: got %h want cafef00d", dl_a); end
    st_a = 1'b0; ld_a = 1'b0;
    step;
    checks++; if (ldn_a !== 1'b0 || sdn_a !== 1'b0) begin errors++; $display("FAIL simul_no_late_done: got s%b l%b want s0 l0", sdn_a, ldn_a); end
    a_op(1'b0, 32'h20, 32'h0, 4'h0, sdn, ldn, dl);
    checks++; if (ldn !== 1'b1 || dl !== 32'h5) begin errors++; $display("FAIL simul_load: got %b/%h want 1/00000005", ldn, dl); end
  endtask

  task automatic test_load_wait;
    logic ok;
    logic [31:0] dl;
    b_op(1'b1, 32'h40, 32'h12345678, 4'hF, ok, dl);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL lw_preload_timeout: got %b want 1", ok); end
    checks++; if (rdy_b !== 1'b1) begin errors++; $display("FAIL lw_ready_c0: got %b want 1", rdy_b); end
    dm_addr = 32'h40; ld_b = 1'b1;
    step;
    checks++; if (rdy_b !== 1'b0 || ldn_b !== 1'b0) begin errors++; $display("FAIL lw_c1: got r%b l%b want r0 l0", rdy_b, ldn_b); end
    ld_b = 1'b0;
    dm_addr = 32'h44; dm_wdata = 32'h0BADF00D; dm_sel = 4'hF; st_b = 1'b1;
    step;
    checks++; if (rdy_b !== 1'b0 || sdn_b !== 1'b0) begin errors++; $display("FAIL lw_c2: got r%b s%b want r0 s0", rdy_b, sdn_b); end
    step;
    checks++; if (rdy_b !== 1'b0) begin errors++; $display("FAIL lw_c3: got r%b want r0", rdy_b); end
    step;
    checks++; if (rdy_b !== 1'b1 || ldn_b !== 1'b1 || sdn_b !== 1'b0) begin errors++; $display("FAIL lw_c4_flags: got r%b l%b s%b want r1 l1 s0", rdy_b, ldn_b, sdn_b); end
    checks++; if (dl_b !== 32'h12345678) begin errors++; $display("FAIL lw_c4_data: got %h want 12345678", dl_b); end
    step;
    checks++; if (ldn_b !== 1'b0 || rdy_b !== 1'b0) begin errors++; $display("FAIL b2b_c5: got l%b r%b want l0 r0", ldn_b, rdy_b); end
    checks++; if (dl_b !== 32'h12345678) begin errors++; $display("FAIL b2b_data_hold: got %h want 12345678", dl_b); end
    st_b = 1'b0;
    step;
    checks++; if (sdn_b !== 1'b0) begin errors++; $display("FAIL b2b_c6: got s%b want s0", sdn_b); end
    step;
    checks++; if (sdn_b !== 1'b1) begin errors++; $display("FAIL b2b_c7_store_done: got s%b want s1", sdn_b); end
    b_op(1'b0, 32'h44, 32'h0, 4'h0, ok, dl);
    checks++; if (ok !== 1'b1 || dl !== 32'h0BADF00D) begin errors++; $display("FAIL b2b_load: got %b/%h want 1/0badf00d", ok, dl); end
  endtask

  task automatic test_reset_mid;
    logic ok;
    logic [31:0] dl;
    b_op(1'b1, 32'h30, 32'h0, 4'hF, ok, dl);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rm_preload_timeout: got %b want 1", ok); end
    dm_addr = 32'h30; dm_wdata = 32'hFFFFFFFF; dm_sel = 4'hF; st_b = 1'b1;
    step;
    checks++; if (rdy_b !== 1'b0) begin errors++; $display("FAIL rm_in_wait: got r%b want r0", rdy_b); end
    st_b = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rdy_b !== 1'b1 || sdn_b !== 1'b0 || ldn_b !== 1'b0) begin errors++; $display("FAIL rm_async_ctrl: got r%b s%b l%b want r1 s0 l0", rdy_b, sdn_b, ldn_b); end
    checks++; if (dl_b !== 32'h0 || im_data_b !== 32'h0 || im_valid_b !== 1'b0) begin errors++; $display("FAIL rm_async_data: got %h %h %b want 0 0 0", dl_b, im_data_b, im_valid_b); end
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    step;
    checks++; if (im_valid_b !== 1'b1 || rdy_b !== 1'b1 || sdn_b !== 1'b0) begin errors++; $display("FAIL rm_post: got v%b r%b s%b want v1 r1 s0", im_valid_b, rdy_b, sdn_b); end
    b_op(1'b0, 32'h30, 32'h0, 4'h0, ok, dl);
    checks++; if (ok !== 1'b1 || dl !== 32'h0) begin errors++; $display("FAIL rm_discarded: got %b/%h want 1/00000000", ok, dl); end
  endtask

  initial begin
    test_reset;
    test_w0;
    test_byte_lanes;
    test_alias;
    test_simultaneous;
    test_load_wait;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/urv_mem_responder.md
Name: urv_mem_responder

Overview:
- Memory-side responder for the uRV CPU's instruction and data memory interfaces.
- Drives im_data/im_valid toward fetch, and dm_data_l/dm_ready/dm_load_done/dm_store_done toward exec and writeback.
- Wraps a dual-port, byte-enabled word RAM. Data-port wait states are programmable so that the CPU stall paths can be exercised in simulation and in small FPGA builds.

Parameters:
- g_mem_words_log2, 12, log2 of RAM depth in 32-bit words (4096 words = 16 KiB).
- g_load_wait, 1, extra wait cycles (0..15) inserted before dm_load_done_o.
- g_store_wait, 0, extra wait cycles (0..15) inserted before dm_store_done_o.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset; asynchronous, active-low.
- im_addr_i  in  32  fetch byte address; word index = bits [g_mem_words_log2+1:2].
- im_data_o  out  32  fetched word, registered.
- im_valid_o  out  1  im_data_o valid.
- dm_addr_i  in  32  data byte address; word index as for im_addr_i.
- dm_data_s_i  in  32  store data.
- dm_data_select_i  in  4  byte enables; bit n writes byte lane n.
- dm_store_i  in  1  store request.
- dm_load_i  in  1  load request.
- dm_data_l_o  out  32  load data, valid while dm_load_done_o=1.
- dm_ready_o  out  1  responder can accept a request this cycle.
- dm_load_done_o  out  1  one-cycle load completion pulse.
- dm_store_done_o  out  1  one-cycle store completion pulse.

Behaviour:
- Reset values: im_data_o=0, im_valid_o=0, dm_data_l_o=0, dm_ready_o=1, both done outputs 0, FSM=IDLE, wait counter=0.
- RAM contents are not reset.
- Fetch port:
  - Synchronous read every cycle: im_data_o <= mem[im_addr_i index].
  - im_valid_o goes 1 on the first rising edge after rst_n_i deasserts, then stays 1.
  - Latency 1 cycle.
- Address decode: upper address bits are ignored, so addresses alias (wrap) modulo RAM size. Bits [1:0] are ignored; the CPU pre-aligns and supplies byte enables.
- Request acceptance: a request is accepted on any edge where (dm_load_i | dm_store_i) & dm_ready_o.
  - On acceptance, latch address, store data, byte enables and type, then go to WAIT.
  - Requests while dm_ready_o=0 are ignored. The CPU holds them until accepted.
- Simultaneous dm_load_i and dm_store_i: store wins; the load is dropped and no load_done is produced.
- FSM states:
  - IDLE: dm_ready_o=1. An accepted request goes to WAIT with counter = g_load_wait or g_store_wait.
  - WAIT: dm_ready_o=0. Counter decrements each cycle; at 0, go to DONE.
  - DONE: exactly one cycle.
    - Load: dm_load_done_o=1, dm_data_l_o = mem[latched index], 32-bit word with no byte masking.
    - Store: dm_store_done_o=1; RAM lanes with select=1 are written at the end of this cycle.
    - dm_ready_o=1 in DONE, so a new request may be accepted on the same edge that leaves DONE (back-to-back, no bubble).
- Latency, counting the acceptance cycle as cycle 0: done is asserted in cycle W+1 (W = wait parameter). With W=0, done is in cycle 1. Throughput is one op per W+1 cycles.
- dm_data_l_o holds its last value outside DONE.
- Hazards:
  - A load accepted on the DONE edge of a store to the same word returns the new data.
  - A fetch port read of a word written in the same cycle returns the old data; the new data is seen next cycle.
- Store with dm_data_select_i=0000 completes normally and writes nothing.
- Reset asserted mid-operation:
  - Immediately forces IDLE and clears the done outputs.
  - A pending store is discarded with no partial write.
  - Next fetch data is undefined until the first post-reset edge.

Decomposition:
- Shared include urv_mem_defs.v: FSM state encodings (IDLE/WAIT/DONE, 2 bits) and the wait-counter width constant (4).
- One sub-module, urv_dpram:
  - Port A is a registered read.
  - Port B is a registered read plus a byte-enabled write.
  - Parameter is the depth log2.
  - Read-during-write on the other port returns old data.
- urv_mem_responder itself holds the FSM, the counter and the request latches.

Test Plan:
- W=0: store 0xDEADBEEF, select 1111, addr 0x100; next cycle load 0x100 -> store_done in cycle 1, load_done in cycle 1 of the load with data 0xDEADBEEF, dm_ready_o never low.
- g_load_wait=3: load addr 0x40 holding 0x12345678 -> dm_ready_o low cycles 1-3, load_done and data 0x12345678 in cycle 4, ready back high in cycle 4.
- Byte lanes: word holds 0xAABBCCDD; store 0x11223344 with select 0101 -> subsequent load returns 0xAA22CC44.
- Aliasing: g_mem_words_log2=12; store 0xCAFEF00D at 0x0000_4008 -> load from 0x0000_0008 returns 0xCAFEF00D; fetch of 0x8 one cycle after store_done shows it.
- Simultaneous load+store to 0x20 with data 0x5 -> only store_done pulses; a following load returns 0x5.
- Reset pulse in the WAIT of a store of 0xFFFFFFFF to 0x30 (old 0x0) -> outputs return to reset values asynchronously; a post-reset load returns 0x0.
